// File: rtl/booth_sequential_multiplier_if.sv
// Operand/result bundle for the Booth sequential multiplier.
// The requester owns start/a/b; the multiplier owns busy/done/product.
interface booth_sequential_multiplier_if #(
  parameter int unsigned N = 8
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/booth_sequential_multiplier.sv
// Radix-2 Booth sequential signed multiplier: one Booth step per clock,
// N steps per operation, 2N-bit product presented with a one-cycle done pulse.
module booth_sequential_multiplier #(
  parameter int unsigned N = 8
) (
  input logic                        clk,
  input logic                        rst,
  booth_sequential_multiplier_if.slave bus
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic           q_m1_q, q_m1_d;
  logic [N:0]     mcand_q, mcand_d;
  logic [N:0]     neg_mcand_q, neg_mcand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N:0]     mcand_ext;
  logic [N:0]     sum;

  // Sign-extend the multiplicand by one bit so its negation never overflows.
  assign mcand_ext = {bus.a[N-1], bus.a};

  // Next-state: load on accepted start, one Booth add/shift per RUN cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    q_m1_d      = q_m1_q;
    mcand_d     = mcand_q;
    neg_mcand_d = neg_mcand_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    sum         = acc_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StRun;
          acc_d       = '0;
          mplier_d    = bus.b;
          q_m1_d      = 1'b0;
          cnt_d       = '0;
          mcand_d     = mcand_ext;
          neg_mcand_d = ~mcand_ext + {{N{1'b0}}, 1'b1};
        end
      end
      StRun: begin
        case ({mplier_q[0], q_m1_q})
          2'b01:   sum = acc_q + mcand_q;
          2'b10:   sum = acc_q + neg_mcand_q;
          default: sum = acc_q;
        endcase
        // Arithmetic right shift of {acc, q, q_m1}.
        acc_d    = {sum[N], sum[N:1]};
        mplier_d = {sum[0], mplier_q[N-1:1]};
        q_m1_d   = mplier_q[0];
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d   = StDone;
          product_d = {acc_d[N-1:0], mplier_d};
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mplier_q    <= '0;
      q_m1_q      <= 1'b0;
      mcand_q     <= '0;
      neg_mcand_q <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      q_m1_q      <= q_m1_d;
      mcand_q     <= mcand_d;
      neg_mcand_q <= neg_mcand_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Self-checking bench for booth_sequential_multiplier: cycle-level behavioural
// model plus directed literal cases and a long randomized run.
module tb_booth_sequential_multiplier;

  localparam int unsigned N = 8;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  booth_sequential_multiplier_if #(.N(N)) bus ();

  booth_sequential_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: m_t counts edges since the accepting edge (-1 when idle).
  int             m_t = -1;
  logic [2*N-1:0] m_pend = '0;
  logic [2*N-1:0] m_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_t    <= -1;
      m_prod <= '0;
    end else if (m_t < 0) begin
      if (bus.start) begin
        m_t    <= 0;
        m_pend <= {{N{bus.a[N-1]}}, bus.a} * {{N{bus.b[N-1]}}, bus.b};
      end
    end else if (m_t == N) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == N) m_prod <= m_pend;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_t >= 0 && m_t < N));
      check("done", 32'(bus.done), 32'(m_t == N));
      check("product", 32'(bus.product), 32'(m_prod));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single operation from idle; checks busy length, one done and the literal product.
  task automatic do_op(input logic [N-1:0] aa, input logic [N-1:0] bb,
                       input logic [2*N-1:0] exp, input string name);
    int nb, nd;
    logic [2*N-1:0] got;
    nb = 0; nd = 0; got = '0;
    bus.start = 1'b1; bus.a = aa; bus.b = bb;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i <= N + 4; i++) begin
      if (bus.busy) nb++;
      if (bus.done) begin nd++; got = bus.product; end
      tick();
    end
    check({name, "_busy_cycles"}, 32'(nb), 32'(N));
    check({name, "_done_count"}, 32'(nd), 32'd1);
    check({name, "_product"}, 32'(got), 32'(exp));
  endtask

  initial begin
    int nd, d1, d2;
    logic [2*N-1:0] p1, p2;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    tick();

    // Basic and extreme operands.
    do_op(8'd3, 8'd4, 16'h000C, "3x4");
    do_op(8'd3, 8'hFB, 16'hFFF1, "3xm5");
    do_op(8'h80, 8'h80, 16'h4000, "m128xm128");
    do_op(8'h80, 8'h7F, 16'hC080, "m128x127");
    do_op(8'hFF, 8'hFF, 16'h0001, "m1xm1");
    do_op(8'h00, 8'hFB, 16'h0000, "0xm5");

    // Start with new operands at E0+3 must be ignored.
    bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd4;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'h9C;
    tick();
    bus.start = 1'b0;
    nd = 0; p1 = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin nd++; p1 = bus.product; end
      tick();
    end
    check("ignore_done_count", 32'(nd), 32'd1);
    check("ignore_product", 32'(p1), 32'h000C);

    // Reset at E0+4 aborts with no done.
    bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd4;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    nd = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (bus.done) nd++;
      tick();
    end
    check("abort_no_done", 32'(nd), 32'd0);
    do_op(8'd7, 8'd6, 16'h002A, "7x6");

    // Back-to-back with start held high.
    bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'hFE;
    tick();
    bus.a = 8'hF7; bus.b = 8'd9;
    nd = 0; d1 = -1; d2 = -1; p1 = '0; p2 = '0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 10) bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (d1 < 0) begin d1 = i; p1 = bus.product; end
        else begin d2 = i; p2 = bus.product; end
      end
    end
    check("b2b_done_count", 32'(nd), 32'd2);
    check("b2b_first_at", 32'(d1), 32'd8);
    check("b2b_first_product", 32'(p1), 32'hFFF6);
    check("b2b_second_at", 32'(d2), 32'd18);
    check("b2b_second_product", 32'(p2), 32'hFFAF);

    // Random stimulus: operands, start pulses and rare resets every cycle.
    for (int k = 0; k < 30000; k++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a     = N'($urandom);
      bus.b     = N'($urandom);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < N + 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
